// File: rtl/pbit_sweep_scheduler_if.sv
// Bus between the p-bit sweep scheduler and its host/sampler:
// config writes, run control, and the per-p-bit update handshake.
interface pbit_sweep_scheduler_if #(
  parameter int N          = 3,
  parameter int INT_SIZE   = 8,
  parameter int FLOAT_SIZE = 24
);
  localparam int W  = INT_SIZE + FLOAT_SIZE;
  localparam int AW = $clog2(N*N + N);
  localparam int IW = $clog2(N);

  logic                 cfg_we;
  logic [AW-1:0]        cfg_addr;
  logic signed [W-1:0]  cfg_data;
  logic                 start;
  logic [15:0]          num_sweeps;
  logic                 upd_req;
  logic [IW-1:0]        upd_idx;
  logic signed [W-1:0]  upd_z;
  logic                 upd_ack;
  logic                 upd_m;
  logic [N-1:0]         m_out;
  logic                 busy;
  logic                 done;
  logic [15:0]          sweep_cnt;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, num_sweeps, upd_ack, upd_m,
    input  upd_req, upd_idx, upd_z, m_out, busy, done, sweep_cnt
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, num_sweeps, upd_ack, upd_m,
    output upd_req, upd_idx, upd_z, m_out, busy, done, sweep_cnt
  );
endinterface

// File: rtl/pbit_sweep_scheduler.sv
// Sequential (Gibbs) sweep scheduler for a small p-bit network: builds each
// p-bit's local field from the current state, hands it out, and folds back the sample.
module pbit_sweep_scheduler #(
  parameter int N          = 3,
  parameter int INT_SIZE   = 8,
  parameter int FLOAT_SIZE = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  pbit_sweep_scheduler_if.slave bus
);
  localparam int W     = INT_SIZE + FLOAT_SIZE;
  localparam int IW    = $clog2(N);
  localparam int AW    = $clog2(N*N + N);
  localparam int WIW   = $clog2(N*N);
  localparam int ACC_W = W + $clog2(N) + 1;

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_BIAS, S_ISSUE, S_DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic signed [W-1:0]     r_w [N*N];
  logic signed [W-1:0]     r_b [N];
  logic signed [ACC_W-1:0] r_acc;
  logic signed [W-1:0]     r_z;
  logic [N-1:0]            r_m;
  logic [15:0]             r_sweep;
  logic [15:0]             r_nsw;
  logic [IW-1:0]           r_i;
  logic [IW-1:0]           r_j;
  logic [WIW-1:0]          r_base;

  logic [WIW-1:0]          w_widx;
  logic signed [W-1:0]     w_wsel;
  logic signed [ACC_W-1:0] w_wext;
  logic signed [ACC_W-1:0] w_term;
  logic signed [ACC_W-1:0] w_bext;
  logic signed [ACC_W-1:0] w_biased;
  logic                    w_last_i;
  logic                    w_last_j;
  logic                    w_more;

  function automatic logic signed [W-1:0] sat_w(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    lo = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
    if (v > hi)      return {1'b0, {(W-1){1'b1}}};
    else if (v < lo) return {1'b1, {(W-1){1'b0}}};
    else             return v[W-1:0];
  endfunction

  // r_base tracks i*N so the weight row is addressed without a multiplier
  assign w_widx   = r_base + WIW'(r_j);
  assign w_wsel   = r_w[w_widx];
  assign w_wext   = {{(ACC_W-W){w_wsel[W-1]}}, w_wsel};
  assign w_term   = (r_j == r_i) ? '0 : (r_m[r_j] ? w_wext : -w_wext);
  assign w_bext   = {{(ACC_W-W){r_b[r_i][W-1]}}, r_b[r_i]};
  assign w_biased = r_acc + w_bext;
  assign w_last_i = (r_i == IW'(N-1));
  assign w_last_j = (r_j == IW'(N-1));
  assign w_more   = ({1'b0, r_sweep} + 17'd1) < {1'b0, r_nsw};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = (bus.num_sweeps != 16'd0) ? S_ACCUM : S_DONE;
      S_ACCUM: if (w_last_j) w_state_nxt = S_BIAS;
      S_BIAS:  w_state_nxt = S_ISSUE;
      S_ISSUE: if (bus.upd_ack) w_state_nxt = (!w_last_i || w_more) ? S_ACCUM : S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N*N; k++) r_w[k] <= '0;
      for (int k = 0; k < N; k++)   r_b[k] <= '0;
      r_acc   <= '0;
      r_z     <= '0;
      r_m     <= '0;
      r_sweep <= '0;
      r_nsw   <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_base  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.cfg_we) begin
            if (bus.cfg_addr < AW'(N*N))
              r_w[WIW'(bus.cfg_addr)] <= bus.cfg_data;
            else if (bus.cfg_addr < AW'(N*N + N))
              r_b[IW'(bus.cfg_addr - AW'(N*N))] <= bus.cfg_data;
          end
          if (bus.start && bus.num_sweeps != 16'd0) begin
            r_nsw   <= bus.num_sweeps;
            r_sweep <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_base  <= '0;
            r_acc   <= '0;
          end
        end
        S_ACCUM: begin
          r_acc <= r_acc + w_term;
          r_j   <= r_j + 1'b1;
        end
        S_BIAS: r_z <= sat_w(w_biased);
        S_ISSUE: begin
          // the new sample lands before the next ACCUM reads r_m
          if (bus.upd_ack) begin
            r_m[r_i] <= bus.upd_m;
            r_acc    <= '0;
            r_j      <= '0;
            if (w_last_i) begin
              r_i     <= '0;
              r_base  <= '0;
              r_sweep <= r_sweep + 16'd1;
            end else begin
              r_i    <= r_i + 1'b1;
              r_base <= r_base + WIW'(N);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.upd_req   = (r_state == S_ISSUE);
  assign bus.upd_idx   = r_i;
  assign bus.upd_z     = r_z;
  assign bus.m_out     = r_m;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.sweep_cnt = r_sweep;
endmodule

// File: tb/tb_pbit_sweep_scheduler.sv
// Bench for pbit_sweep_scheduler: directed scenarios plus randomized runs
// scored against an arithmetic Gibbs-sweep reference model.
module tb_pbit_sweep_scheduler;
  localparam int N  = 3;
  localparam int AW = $clog2(N*N + N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pbit_sweep_scheduler_if #(.N(N)) bus ();

  pbit_sweep_scheduler #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int           n_vec = 0;
  int           n_err = 0;
  int           mw [N][N];
  int           mb [N];
  bit           mm [N];
  logic [31:0]  zseen [N];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] mvec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = mm[i];
    return v;
  endfunction

  // Local field of p-bit i: sum over j != i of s_j*w[i][j] plus b[i], clamped to 32 bits
  function automatic logic [31:0] model_z(input int i);
    longint s;
    s = longint'(mb[i]);
    for (int j = 0; j < N; j++)
      if (j != i) s += mm[j] ? longint'(mw[i][j]) : -longint'(mw[i][j]);
    if (s > 64'sd2147483647)       s = 64'sd2147483647;
    else if (s < -64'sd2147483648) s = -64'sd2147483648;
    return 32'(s);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mb[i] = 0;
      mm[i] = 1'b0;
      for (int j = 0; j < N; j++) mw[i][j] = 0;
    end
  endtask

  task automatic quiet();
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_data   = '0;
    bus.start      = 1'b0;
    bus.upd_ack    = 1'b0;
    bus.upd_m      = 1'b0;
  endtask

  task automatic noise();
    bus.cfg_we     = 1'($urandom);
    bus.cfg_addr   = AW'($urandom);
    bus.cfg_data   = 32'($urandom);
    bus.start      = 1'($urandom);
    bus.num_sweeps = 16'($urandom);
    bus.upd_m      = 1'($urandom);
    bus.upd_ack    = bus.upd_req ? 1'b0 : 1'($urandom);
  endtask

  task automatic wr(input int addr, input logic [31:0] d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = AW'(addr);
    bus.cfg_data = d;
    tick();
    bus.cfg_we   = 1'b0;
    if (addr < N*N)          mw[addr / N][addr % N] = int'(d);
    else if (addr < N*N + N) mb[addr - N*N] = int'(d);
  endtask

  task automatic do_run(input int nsw, input int dmin, input int dmax, input int mpat, input bit noisy);
    int          cnt;
    int          d;
    bit          m;
    logic [31:0] zexp;
    logic [N-1:0] mprev;
    mprev = mvec();
    bus.num_sweeps = 16'(nsw);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    if (nsw == 0) begin
      chk("nsw0_done", 32'(bus.done), 32'd1);
      chk("nsw0_req", 32'(bus.upd_req), 32'd0);
      tick();
      chk("nsw0_idle", {30'd0, bus.busy, bus.done}, 32'd0);
      chk("nsw0_m", 32'(bus.m_out), 32'(mprev));
      return;
    end
    for (int s = 0; s < nsw; s++) begin
      for (int i = 0; i < N; i++) begin
        cnt = (s == 0 && i == 0) ? 1 : 0;
        while (!bus.upd_req && cnt < 100) begin
          if (noisy) noise();
          tick();
          cnt++;
        end
        if (!bus.upd_req) begin
          chk("req_timeout", 32'(bus.upd_req), 32'd1);
          $fatal(1, "no update request");
        end
        chk("latency", 32'(cnt), (s == 0 && i == 0) ? 32'(N + 2) : 32'(N + 1));
        zexp = model_z(i);
        chk("upd_idx", 32'(bus.upd_idx), 32'(i));
        chk("upd_z", bus.upd_z, zexp);
        chk("sweep_mid", 32'(bus.sweep_cnt), 32'(s));
        chk("m_mid", 32'(bus.m_out), 32'(mvec()));
        d = int'($urandom_range(dmax, dmin));
        repeat (d) begin
          if (noisy) noise();
          bus.upd_ack = 1'b0;
          tick();
          chk("stall_req", 32'(bus.upd_req), 32'd1);
          chk("stall_z", bus.upd_z, zexp);
        end
        m = (mpat < 0) ? 1'($urandom) : 1'((mpat >> i) & 1);
        if (noisy) noise();
        bus.upd_ack = 1'b1;
        bus.upd_m   = m;
        tick();
        bus.upd_ack = 1'b0;
        mm[i]    = m;
        zseen[i] = zexp;
      end
    end
    quiet();
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("sweep_final", 32'(bus.sweep_cnt), 32'(nsw));
    tick();
    chk("done_drop", {30'd0, bus.busy, bus.done}, 32'd0);
    chk("m_hold", 32'(bus.m_out), 32'(mvec()));
    chk("sweep_hold", 32'(bus.sweep_cnt), 32'(nsw));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    quiet();
    bus.num_sweeps = '0;
    bus.upd_ack = 1'b1;
    model_clear();
    for (int i = 0; i < N; i++) zseen[i] = '0;
    repeat (3) tick();
    rst = 1'b0;
    bus.upd_ack = 1'b0;
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_req", 32'(bus.upd_req), 32'd0);
    chk("rst_idx", 32'(bus.upd_idx), 32'd0);
    chk("rst_z", bus.upd_z, 32'd0);
    chk("rst_m", 32'(bus.m_out), 32'd0);
    chk("rst_sweep", 32'(bus.sweep_cnt), 32'd0);

    // Bias only
    wr(9, 32'h0080_0000);
    do_run(1, 0, 0, -1, 1'b0);
    chk("bias_z0", zseen[0], 32'h0080_0000);

    // Sequential coupling through w[1][0]
    wr(9, 32'h0);
    wr(3, 32'h0100_0000);
    do_run(1, 0, 1, 1, 1'b0);
    chk("couple_pos", zseen[1], 32'h0100_0000);
    do_run(1, 0, 1, 0, 1'b0);
    chk("couple_neg", zseen[1], 32'hFF00_0000);

    // Saturation, positive then negative
    wr(3, 32'h0);
    wr(1, 32'h7F00_0000);
    wr(2, 32'h7F00_0000);
    wr(9, 32'h7F00_0000);
    do_run(2, 0, 1, 7, 1'b1);
    chk("sat_pos", zseen[0], 32'h7FFF_FFFF);
    wr(1, 32'h8100_0000);
    wr(2, 32'h8100_0000);
    wr(9, 32'h8100_0000);
    do_run(2, 0, 1, 7, 1'b1);
    chk("sat_neg", zseen[0], 32'h8000_0000);

    // Diagonal ignored, long ack stall
    wr(1, 32'h0);
    wr(2, 32'h0);
    wr(9, 32'h0);
    wr(0, 32'h7F00_0000);
    do_run(1, 7, 7, 7, 1'b0);
    chk("diag_z0", zseen[0], 32'h0);

    // Zero sweeps
    do_run(0, 0, 0, -1, 1'b0);

    // Randomized networks
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < N*N + N; a++)
        wr(a, ($urandom_range(3, 0) == 0) ? 32'($urandom)
                                          : 32'($urandom_range(32'h0400_0000, 0)) - 32'h0200_0000);
      wr(N*N + N + int'($urandom_range(32'((1 << AW) - N*N - N - 1), 0)), 32'($urandom));
      do_run(int'($urandom_range(3, 1)), 0, 3, -1, 1'b1);
    end

    // Reset in the third ISSUE cycle, with an ack in the same cycle
    do_run(1, 0, 0, 7, 1'b0);
    bus.num_sweeps = 16'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cnt = 1;
    while (!bus.upd_req && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("mid_lat", 32'(cnt), 32'(N + 2));
    tick();
    tick();
    chk("mid_req3", 32'(bus.upd_req), 32'd1);
    rst = 1'b1;
    bus.upd_ack = 1'b1;
    bus.upd_m = 1'b1;
    tick();
    rst = 1'b0;
    bus.upd_ack = 1'b0;
    model_clear();
    chk("mid_busy", 32'(bus.busy), 32'd0);
    chk("mid_m", 32'(bus.m_out), 32'd0);
    chk("mid_req", 32'(bus.upd_req), 32'd0);
    chk("mid_z", bus.upd_z, 32'd0);
    chk("mid_sweep", 32'(bus.sweep_cnt), 32'd0);

    // Config writes while busy must not land
    do_run(2, 0, 2, -1, 1'b1);
    for (int i = 0; i < N; i++) chk("post_rst_z", zseen[i], 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
